ps2_frame_rx: RTL and testbench
===============================

PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 The block SHALL expose parameter FILTER_W, default 8: debounce shift-register length, in clk cycles.
REQ-002 The block SHALL expose parameter TIMEOUT_CYC, default 100000: maximum clk cycles allowed between falling edges inside a frame (2 ms at 50 MHz).
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 ps2d  input  1  PS/2 data line; asynchronous.
REQ-006 ps2c  input  1  PS/2 clock line; asynchronous.
REQ-007 rx_en  input  1  reception enable; sampled only in IDLE.
REQ-008 rx_done_tick  output  1  one-cycle pulse; a complete frame is available.
REQ-009 dout  output  8  received data byte; valid from rx_done_tick until the next rx_done_tick.
REQ-010 parity_err  output  1  odd-parity failure for the frame in dout; valid with dout.
REQ-011 frame_err  output  1  start bit not 0 or stop bit not 1 for the frame in dout; valid with dout.
REQ-012 timeout_tick  output  1  one-cycle pulse; the current frame was aborted.

Function
REQ-013 ps2c and ps2d SHALL each pass through a 2-flop synchronizer before any use.
REQ-014 Debounce: synchronized ps2c SHALL shift into a FILTER_W-bit register every cycle.
- Filtered clock goes to 1 when the register is all ones and to 0 when it is all zeros; otherwise it holds.
REQ-015 fall_tick SHALL be 1 for exactly one cycle when the filtered clock goes from 1 to 0.
REQ-016 Frame format: 11 bits, LSB first: start(0), d0..d7, odd parity, stop(1). One bit is sampled from synchronized ps2d on each fall_tick.
REQ-017 The FSM SHALL have the states IDLE, DPS and LOAD.
REQ-018 IDLE -> DPS on fall_tick with rx_en=1.
- The start bit is shifted in and the bit counter is loaded with 9.
- A start bit of 1 is captured as-is and reported through frame_err.
REQ-019 In DPS, each fall_tick SHALL right-shift ps2d into the MSB of an 11-bit frame register.
- The counter decrements; the fall_tick with counter==0 moves the FSM to LOAD.
REQ-020 LOAD SHALL last one cycle, assert rx_done_tick, update the outputs as follows, and return to IDLE.
- dout = frame[8:1]
- parity_err = ~^frame[9:1]
- frame_err = frame[0] | ~frame[10]
REQ-021 Latency: rx_done_tick SHALL occur exactly one clk after the fall_tick of the 11th bit.
REQ-022 The block SHALL produce exactly one rx_done_tick per frame; a frame carrying errors still produces rx_done_tick.
REQ-023 Timeout counter: cleared on entry to DPS and on every fall_tick in DPS; increments otherwise.
- When it reaches TIMEOUT_CYC-1, the FSM goes to IDLE, timeout_tick pulses, and there is no rx_done_tick.
- dout, parity_err and frame_err are unchanged by a timeout.
REQ-024 Deasserting rx_en mid-frame SHALL NOT abort reception; the frame completes normally.
REQ-025 In IDLE, a fall_tick with rx_en=0 SHALL be ignored.
REQ-026 rx_done_tick and timeout_tick SHALL never be asserted in the same cycle.

Reset
REQ-027 On rst=1 at a clk edge, the block SHALL apply these values:
- FSM = IDLE; counters = 0.
- Frame register = 0; dout = 8'h00.
- parity_err, frame_err, rx_done_tick, timeout_tick = 0.
- Synchronizers and filter register = all ones (line idle high).
REQ-028 Reset mid-frame SHALL discard the partial frame with no output pulse.
- The first fall_tick after reset is treated as a new start bit.

Structure
REQ-029 A shared package ps2_pkg SHALL hold:
- the state enum (IDLE, DPS, LOAD);
- PS2_FRAME_BITS = 11;
- PS2_DATA_BITS = 8.
REQ-030 Synchronizer, debounce filter and edge detector SHALL form one sub-module, ps2_clk_filter, with output fall_tick. The FSM, shift register and timeout counter SHALL live in ps2_frame_rx.

Verification
REQ-031 Good frame: 0x1C with parity bit 0, 30 us bit period, rx_en=1 -> one rx_done_tick, dout=0x1C, parity_err=0, frame_err=0.
REQ-032 Bad parity: 0x1C sent with parity bit 1 -> rx_done_tick, dout=0x1C, parity_err=1, frame_err=0.
REQ-033 Glitch: ps2c low pulse of FILTER_W-2 cycles inside a frame -> no extra bit; a following 0xF0 frame is received correctly.
REQ-034 Timeout: 5 bits sent, then lines held high -> timeout_tick exactly TIMEOUT_CYC-1 cycles after the last fall_tick, no rx_done_tick, dout unchanged; a following 0x29 frame yields dout=0x29.
REQ-035 Enable: a frame sent with rx_en=0 -> no output pulses. rx_en dropped after bit 3 of a 0x5A frame -> rx_done_tick with dout=0x5A.
REQ-036 Reset: rst pulsed after bit 6 of a frame -> all outputs 0, no pulses; a following 0x1C frame is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver types and frame constants
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DPS, LOAD} state_t;
  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;
endpackage

// File: rtl/ps2_frame_rx_if.sv
// ps2_frame_rx_if: PS/2 line inputs and received-frame outputs
interface ps2_frame_rx_if;
  import ps2_pkg::*;
  logic ps2d;
  logic ps2c;
  logic rx_en;
  logic rx_done_tick;
  logic [PS2_DATA_BITS-1:0] dout;
  logic parity_err;
  logic frame_err;
  logic timeout_tick;
  modport master (output ps2d, ps2c, rx_en, input rx_done_tick, dout, parity_err, frame_err, timeout_tick);
  modport slave (input ps2d, ps2c, rx_en, output rx_done_tick, dout, parity_err, frame_err, timeout_tick);
endinterface

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronizes PS/2 lines, debounces ps2c and flags its falling edges
module ps2_clk_filter #(
  parameter int FILTER_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2c,
  input  logic ps2d,
  output logic fall_tick,
  output logic ps2d_sync
);
  logic [1:0] c_sync, d_sync;
  logic [FILTER_W-1:0] filt;
  logic f_val, f_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      c_sync <= '1;
      d_sync <= '1;
      filt   <= '1;
      f_val  <= 1'b1;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
      filt   <= {filt[FILTER_W-2:0], c_sync[1]};
      f_val  <= f_next;
    end
  end
  assign f_next    = &filt ? 1'b1 : ~|filt ? 1'b0 : f_val;
  assign fall_tick = f_val & ~f_next;
  assign ps2d_sync = d_sync[1];
endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver with parity, framing and timeout checks
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_W    = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input logic clk,
  input logic rst,
  ps2_frame_rx_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 2);
  state_t state, state_n;
  logic [PS2_FRAME_BITS-1:0] frame, frame_n, shift;
  logic [PS2_DATA_BITS-1:0] dout_r, dout_n;
  logic [3:0] cnt, cnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic perr_r, perr_n, ferr_r, ferr_n, done, tout;
  logic fall_tick, ps2d_sync;
  ps2_clk_filter #(.FILTER_W(FILTER_W)) u_filt (
    .clk(clk), .rst(rst), .ps2c(bus.ps2c), .ps2d(bus.ps2d),
    .fall_tick(fall_tick), .ps2d_sync(ps2d_sync)
  );
  assign shift = {ps2d_sync, frame[PS2_FRAME_BITS-1:1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      frame  <= '0;
      cnt    <= '0;
      tcnt   <= '0;
      dout_r <= '0;
      perr_r <= 1'b0;
      ferr_r <= 1'b0;
    end else begin
      state  <= state_n;
      frame  <= frame_n;
      cnt    <= cnt_n;
      tcnt   <= tcnt_n;
      dout_r <= dout_n;
      perr_r <= perr_n;
      ferr_r <= ferr_n;
    end
  end
  // Outputs are latched on the last fall_tick so they are already valid while LOAD pulses done.
  always_comb begin
    state_n = state;
    frame_n = frame;
    cnt_n   = cnt;
    tcnt_n  = '0;
    dout_n  = dout_r;
    perr_n  = perr_r;
    ferr_n  = ferr_r;
    done    = 1'b0;
    tout    = 1'b0;
    case (state)
      IDLE: if (fall_tick && bus.rx_en) begin
        state_n = DPS;
        frame_n = shift;
        cnt_n   = 4'd9;
      end
      DPS: if (fall_tick) begin
        frame_n = shift;
        cnt_n   = cnt - 4'd1;
        if (cnt == 4'd0) begin
          state_n = LOAD;
          dout_n  = shift[8:1];
          perr_n  = ~^shift[9:1];
          ferr_n  = shift[0] | ~shift[PS2_FRAME_BITS-1];
        end
      end else if (tcnt == TLAST) begin
        state_n = IDLE;
        tout    = 1'b1;
      end else begin
        tcnt_n = tcnt + TW'(1);
      end
      LOAD: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.rx_done_tick = done;
  assign bus.timeout_tick = tout;
  assign bus.dout         = dout_r;
  assign bus.parity_err   = perr_r;
  assign bus.frame_err    = ferr_r;
endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: directed scenario checks for the PS/2 frame receiver
module tb_ps2_frame_rx;
  localparam int FW   = 8;
  localparam int TO   = 400;
  localparam int HALF = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, fall_cyc = 0, done_cyc = 0, to_cyc = 0;
  int done_cnt = 0, to_cnt = 0, both_cnt = 0;
  int compared = 0, mismatched = 0;
  ps2_frame_rx_if bus ();
  ps2_frame_rx #(.FILTER_W(FW), .TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.rx_done_tick) begin done_cnt++; done_cyc = cyc; end
    if (bus.timeout_tick) begin to_cnt++; to_cyc = cyc; end
    if (bus.rx_done_tick && bus.timeout_tick) both_cnt++;
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    bus.ps2d = b;
    wait_cyc(HALF);
    bus.ps2c = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    bus.ps2c = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int nbits, input int glitch_at, input int en_off_at);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      send_bit(bits[i]);
      if (i == glitch_at) begin
        wait_cyc(3);
        bus.ps2c = 1'b0;
        wait_cyc(FW - 2);
        bus.ps2c = 1'b1;
      end
      if (i == en_off_at) bus.rx_en = 1'b0;
    end
    wait_cyc(FW + 10);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    wait_cyc(4);
    @(negedge clk);
    compared++; if (bus.dout !== 8'h00) begin mismatched++; $display("FAIL reset_dout: got %h want 00", bus.dout); end
    compared++; if (bus.parity_err !== 1'b0) begin mismatched++; $display("FAIL reset_perr: got %b want 0", bus.parity_err); end
    compared++; if (bus.frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_ferr: got %b want 0", bus.frame_err); end
    compared++; if (bus.rx_done_tick !== 1'b0 || bus.timeout_tick !== 1'b0) begin mismatched++; $display("FAIL reset_ticks: got %b%b want 00", bus.rx_done_tick, bus.timeout_tick); end
    rst = 1'b0;
    wait_cyc(5);
  endtask
  task automatic test_good;
    int d0 = done_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1, -1);
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL good_pulses: got %0d want 1", done_cnt - d0); end
    compared++; if (bus.dout !== 8'h1C) begin mismatched++; $display("FAIL good_dout: got %h want 1c", bus.dout); end
    compared++; if (bus.parity_err !== 1'b0 || bus.frame_err !== 1'b0) begin mismatched++; $display("FAIL good_errs: got %b%b want 00", bus.parity_err, bus.frame_err); end
    compared++; if (done_cyc - fall_cyc !== FW + 3) begin mismatched++; $display("FAIL good_latency: got %0d want %0d", done_cyc - fall_cyc, FW + 3); end
  endtask
  task automatic test_bad_parity;
    int d0 = done_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 11, -1, -1);
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL par_pulses: got %0d want 1", done_cnt - d0); end
    compared++; if (bus.dout !== 8'h1C) begin mismatched++; $display("FAIL par_dout: got %h want 1c", bus.dout); end
    compared++; if (bus.parity_err !== 1'b1 || bus.frame_err !== 1'b0) begin mismatched++; $display("FAIL par_errs: got %b%b want 10", bus.parity_err, bus.frame_err); end
  endtask
  task automatic test_bad_stop;
    int d0 = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 11, -1, -1);
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL stop_pulses: got %0d want 1", done_cnt - d0); end
    compared++; if (bus.dout !== 8'hA5 || bus.parity_err !== 1'b0 || bus.frame_err !== 1'b1) begin mismatched++; $display("FAIL stop_out: got %h %b%b want a5 01", bus.dout, bus.parity_err, bus.frame_err); end
  endtask
  task automatic test_glitch;
    int d0 = done_cnt;
    send_frame(8'hF0, 1'b1, 1'b1, 11, 4, -1);
    compared++; if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL glitch_pulses: got %0d want 1", done_cnt - d0); end
    compared++; if (bus.dout !== 8'hF0 || bus.parity_err !== 1'b0 || bus.frame_err !== 1'b0) begin mismatched++; $display("FAIL glitch_out: got %h %b%b want f0 00", bus.dout, bus.parity_err, bus.frame_err); end
  endtask
  task automatic test_timeout;
    int d0 = done_cnt;
    int t0 = to_cnt;
    send_frame(8'h55, 1'b1, 1'b1, 5, -1, -1);
    wait_cyc(TO + 40);
    compared++; if (to_cnt - t0 !== 1) begin mismatched++; $display("FAIL to_pulses: got %0d want 1", to_cnt - t0); end
    compared++; if (done_cnt - d0 !== 0) begin mismatched++; $display("FAIL to_done: got %0d want 0", done_cnt - d0); end
    compared++; if (to_cyc - fall_cyc !== FW + 2 + TO - 1) begin mismatched++; $display("FAIL to_delay: got %0d want %0d", to_cyc - fall_cyc, FW + 2 + TO - 1); end
    compared++; if (bus.dout !== 8'hF0) begin mismatched++; $display("FAIL to_dout: got %h want f0", bus.dout); end
    send_frame(8'h29, 1'b0, 1'b1, 11, -1, -1);
    compared++; if (done_cnt - d0 !== 1 || bus.dout !== 8'h29) begin mismatched++; $display("FAIL to_next: got %0d %h want 1 29", done_cnt - d0, bus.dout); end
  endtask
  task automatic test_enable;
    int d0 = done_cnt;
    int t0 = to_cnt;
    bus.rx_en = 1'b0;
    send_frame(8'h33, 1'b1, 1'b1, 11, -1, -1);
    wait_cyc(TO + 20);
    compared++; if (done_cnt - d0 !== 0 || to_cnt - t0 !== 0) begin mismatched++; $display("FAIL en_off: got %0d %0d want 0 0", done_cnt - d0, to_cnt - t0); end
    compared++; if (bus.dout !== 8'h29) begin mismatched++; $display("FAIL en_off_dout: got %h want 29", bus.dout); end
    bus.rx_en = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b1, 11, -1, 3);
    compared++; if (done_cnt - d0 !== 1 || bus.dout !== 8'h5A) begin mismatched++; $display("FAIL en_drop: got %0d %h want 1 5a", done_cnt - d0, bus.dout); end
    bus.rx_en = 1'b1;
  endtask
  task automatic test_reset_mid;
    int d0 = done_cnt;
    int t0 = to_cnt;
    send_frame(8'h77, 1'b0, 1'b1, 7, -1, -1);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(TO + 20);
    compared++; if (bus.dout !== 8'h00 || bus.parity_err !== 1'b0 || bus.frame_err !== 1'b0) begin mismatched++; $display("FAIL rmid_out: got %h %b%b want 00 00", bus.dout, bus.parity_err, bus.frame_err); end
    compared++; if (done_cnt - d0 !== 0 || to_cnt - t0 !== 0) begin mismatched++; $display("FAIL rmid_pulses: got %0d %0d want 0 0", done_cnt - d0, to_cnt - t0); end
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1, -1);
    compared++; if (done_cnt - d0 !== 1 || bus.dout !== 8'h1C || bus.parity_err !== 1'b0 || bus.frame_err !== 1'b0) begin mismatched++; $display("FAIL rmid_next: got %0d %h %b%b want 1 1c 00", done_cnt - d0, bus.dout, bus.parity_err, bus.frame_err); end
  endtask
  initial begin
    bus.ps2c = 1'b1;
    bus.ps2d = 1'b1;
    bus.rx_en = 1'b1;
    test_reset;
    test_good;
    test_bad_parity;
    test_bad_stop;
    test_glitch;
    test_timeout;
    test_enable;
    test_reset_mid;
    compared++; if (both_cnt !== 0) begin mismatched++; $display("FAIL tick_overlap: got %0d want 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
